tdi_rle_decoder: RTL and testbench

- Synthesizable receive-side decoder for the run-length-compressed TDI AXI-Stream that the TDI processing path sends to DMA.
- Accepts 512-bit compressed beats, expands (count, pixel) tokens into 8-bit pixels, and emits 512-bit beats of 64 pixels, one AXIS packet per line.
- Replaces the simulation-only decompression checker in loopback/self-test builds.
- Reports line count and line-length errors.

---
 rtl/tdi_rle_decoder.sv | 161 ++++++++++++++++
 tb/tb_tdi_rle_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdi_rle_decoder.sv
// Run-length decoder for the compressed TDI stream: expands {count, pixel} tokens
// into 64-pixel AXIS beats, one packet per line, with line count and length check.
module tdi_rle_decoder #(
  parameter int LINE_PIXELS = 8192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  output logic [511:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic [31:0]  o_line_cnt,
  output logic         o_len_err
);

  logic [511:0] r_buf_data;
  logic         r_buf_last;
  logic         r_buf_full;
  logic [4:0]   r_tok_idx;
  logic         r_tok_act;
  logic [7:0]   r_rem;
  logic [511:0] r_asm;
  logic [6:0]   r_fill;
  logic [23:0]  r_px_total;
  logic         r_eol_pend;
  logic [511:0] r_out_data;
  logic         r_out_valid;
  logic         r_out_last;
  logic [31:0]  r_line_cnt;
  logic         r_len_err;

  logic [15:0]  w_tok;
  logic [7:0]   w_cnt;
  logic [7:0]   w_pix;
  logic [7:0]   w_eff_rem;
  logic [6:0]   w_space;
  logic [6:0]   w_n;
  logic [6:0]   w_fill_nxt;
  logic [7:0]   w_rem_left;
  logic         w_tok_done;
  logic [24:0]  w_sum;
  logic [23:0]  w_total_nxt;
  logic [511:0] w_asm_wr;
  logic         w_out_free;
  logic         w_busy;
  logic         w_need_xfer;
  logic         w_xfer_full;
  logic         w_step;
  logic         w_eol_done;

  // A token not yet entered takes its count straight from the buffer.
  assign w_tok       = r_buf_data[{r_tok_idx, 4'b0000} +: 16];
  assign w_cnt       = w_tok[15:8];
  assign w_pix       = w_tok[7:0];
  assign w_eff_rem   = r_tok_act ? r_rem : w_cnt;
  assign w_space     = 7'd64 - r_fill;
  assign w_n         = ({1'b0, w_space} < w_eff_rem) ? w_space : w_eff_rem[6:0];
  assign w_fill_nxt  = r_fill + w_n;
  assign w_rem_left  = w_eff_rem - {1'b0, w_n};
  assign w_tok_done  = (w_rem_left == 8'd0);
  assign w_sum       = {1'b0, r_px_total} + 25'(w_n);
  assign w_total_nxt = w_sum[24] ? 24'hFF_FFFF : w_sum[23:0];

  assign w_out_free  = ~r_out_valid | m_axis_tready;
  assign w_busy      = r_buf_full & ~r_eol_pend;
  // A full assembly is only released once another pixel is known to follow.
  assign w_need_xfer = w_busy & (r_fill == 7'd64) & (w_eff_rem != 8'd0);
  assign w_xfer_full = w_need_xfer & w_out_free;
  assign w_step      = w_busy & ~w_need_xfer;
  assign w_eol_done  = r_eol_pend & ((r_fill == 7'd0) | w_out_free);

  // NOTE: w_asm_wr is given its full default before the loop so no latch is inferred.
  always_comb begin
    w_asm_wr = r_asm;
    for (int k = 0; k < 64; k++) begin
      if ((7'(k) >= r_fill) && (7'(k) < w_fill_nxt)) w_asm_wr[8*k +: 8] = w_pix;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide buffer and assembly registers are cleared too, so no stale line data survives a reset.
      r_buf_data  <= '0;
      r_buf_last  <= 1'b0;
      r_buf_full  <= 1'b0;
      r_tok_idx   <= '0;
      r_tok_act   <= 1'b0;
      r_rem       <= '0;
      r_asm       <= '0;
      r_fill      <= '0;
      r_px_total  <= '0;
      r_eol_pend  <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_line_cnt  <= '0;
      r_len_err   <= 1'b0;
    end else begin
      if (s_axis_tvalid && s_axis_tready) begin
        r_buf_data <= s_axis_tdata;
        r_buf_last <= s_axis_tlast;
        r_buf_full <= 1'b1;
      end

      if (m_axis_tready) r_out_valid <= 1'b0;

      if (w_step) begin
        r_asm      <= w_asm_wr;
        r_fill     <= w_fill_nxt;
        r_px_total <= w_total_nxt;
        if (w_tok_done) begin
          r_tok_act <= 1'b0;
          r_tok_idx <= r_tok_idx + 5'd1;
          if (r_tok_idx == 5'd31) begin
            r_buf_full <= 1'b0;
            r_eol_pend <= r_buf_last;
          end
        end else begin
          r_tok_act <= 1'b1;
          r_rem     <= w_rem_left;
        end
      end

      if (w_xfer_full) begin
        r_out_data  <= r_asm;
        r_out_last  <= 1'b0;
        r_out_valid <= 1'b1;
        r_asm       <= '0;
        r_fill      <= '0;
      end

      // Line end: flush any partial assembly (unwritten bytes are already zero).
      if (w_eol_done) begin
        if (r_fill != 7'd0) begin
          r_out_data  <= r_asm;
          r_out_last  <= 1'b1;
          r_out_valid <= 1'b1;
        end
        r_line_cnt <= r_line_cnt + 32'd1;
        if (r_px_total != 24'(LINE_PIXELS)) r_len_err <= 1'b1;
        r_asm      <= '0;
        r_fill     <= '0;
        r_px_total <= '0;
        r_eol_pend <= 1'b0;
      end
    end
  end

  assign s_axis_tready = ~r_buf_full & ~rst;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tlast  = r_out_last;
  assign o_line_cnt    = r_line_cnt;
  assign o_len_err     = r_len_err;

endmodule

// File: tb/tb_tdi_rle_decoder.sv
// Bench for tdi_rle_decoder: directed lines plus random token streams, checked
// against a byte-queue expansion model of each line.
module tb_tdi_rle_decoder;

  localparam int LP = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic [511:0] m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready = 1'b1;
  logic [31:0]  line_cnt;
  logic         len_err;

  always #5 clk = ~clk;

  tdi_rle_decoder #(.LINE_PIXELS(LP)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .o_line_cnt    (line_cnt),
    .o_len_err     (len_err)
  );

  int           total_n = 0;
  int           bad_n = 0;
  logic [511:0] line_q[$];
  logic [511:0] exp_d[$];
  logic         exp_l[$];
  logic [511:0] rcv_d[$];
  logic         rcv_l[$];
  logic [31:0]  exp_cnt = '0;
  logic         exp_err = 1'b0;
  bit           hold_low = 1'b0;
  bit           bp_en = 1'b0;

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_tready = hold_low ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      rcv_d.push_back(m_tdata);
      rcv_l.push_back(m_tlast);
    end
  end

  // Reference: expand every token of the line into a flat pixel list, then cut into 64-byte beats.
  task automatic model_line();
    logic [7:0]   px[$];
    logic [511:0] bt;
    logic [511:0] d;
    logic [7:0]   c;
    int           total;
    int           nb;
    foreach (line_q[b]) begin
      bt = line_q[b];
      for (int j = 0; j < 32; j++) begin
        c = bt[16*j+8 +: 8];
        repeat (int'(c)) px.push_back(bt[16*j +: 8]);
      end
    end
    total = px.size();
    nb = (total + 63) / 64;
    for (int i = 0; i < nb; i++) begin
      d = '0;
      for (int k = 0; k < 64; k++) if (i*64 + k < total) d[8*k +: 8] = px[i*64 + k];
      exp_d.push_back(d);
      exp_l.push_back(i == nb - 1);
    end
    exp_cnt++;
    if (total != LP) exp_err = 1'b1;
  endtask

  task automatic send_beat(logic [511:0] d, logic last);
    bit ok = 1'b0;
    @(negedge clk);
    s_tdata = d;
    s_tlast = last;
    s_tvalid = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check("in_ready_timeout", 512'(s_tready), 512'd1);
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic send_line();
    for (int i = 0; i < line_q.size(); i++) send_beat(line_q[i], i == line_q.size() - 1);
  endtask

  task automatic finish_line(string tag);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (line_cnt == exp_cnt && rcv_d.size() >= exp_d.size()) break;
    end
    repeat (4) @(posedge clk);
    check({tag, "_nbeats"}, 512'(rcv_d.size()), 512'(exp_d.size()));
    while (exp_d.size() > 0 && rcv_d.size() > 0) begin
      check({tag, "_data"}, rcv_d.pop_front(), exp_d.pop_front());
      check({tag, "_last"}, 512'(rcv_l.pop_front()), 512'(exp_l.pop_front()));
    end
    exp_d.delete(); exp_l.delete(); rcv_d.delete(); rcv_l.delete();
    check({tag, "_cnt"}, 512'(line_cnt), 512'(exp_cnt));
    check({tag, "_err"}, 512'(len_err), 512'(exp_err));
  endtask

  task automatic run_line(string tag);
    model_line();
    send_line();
    finish_line(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_tvalid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 512'(s_tready), 512'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", 512'(s_tready), 512'd1);
    check("rst_m_valid", 512'(m_tvalid), 512'd0);
    check("rst_m_data", m_tdata, 512'd0);
    check("rst_m_last", 512'(m_tlast), 512'd0);
    check("rst_line_cnt", 512'(line_cnt), 512'd0);
    check("rst_len_err", 512'(len_err), 512'd0);
    exp_d.delete(); exp_l.delete(); rcv_d.delete(); rcv_l.delete();
    exp_cnt = '0;
    exp_err = 1'b0;
  endtask

  task automatic one_beat(logic [15:0] t0, logic [15:0] t1, logic [15:0] t2, logic [15:0] t3);
    logic [511:0] b;
    b = '0;
    b[15:0] = t0;
    b[31:16] = t1;
    b[47:32] = t2;
    b[63:48] = t3;
    line_q.delete();
    line_q.push_back(b);
  endtask

  // Random line: tokens summing to target, interleaved with pads carrying junk pixels.
  task automatic gen_line(int target);
    logic [511:0] b;
    logic [15:0]  tk;
    int           rem;
    int           slot;
    int           c;
    line_q.delete();
    b = '0;
    slot = 0;
    rem = target;
    while (rem > 0) begin
      if ($urandom_range(0, 2) == 0) begin
        tk = {8'h00, 8'($urandom)};
      end else begin
        c = $urandom_range(1, (rem > 255) ? 255 : rem);
        tk = {8'(c), 8'($urandom)};
        rem -= c;
      end
      b[16*slot +: 16] = tk;
      slot++;
      if (slot == 32) begin
        line_q.push_back(b);
        b = '0;
        slot = 0;
      end
    end
    if (slot != 0 || line_q.size() == 0) line_q.push_back(b);
  endtask

  initial begin
    bit ok;
    do_reset();

    one_beat(16'h0A55, 16'h3611, 16'h0000, 16'h0000);
    run_line("c1");

    one_beat(16'h0507, 16'h0000, 16'h0000, 16'h0000);
    run_line("c3");
    one_beat(16'h4012, 16'h0000, 16'h0000, 16'h0000);
    run_line("c3_sticky");

    do_reset();
    one_beat(16'hFF01, 16'h0102, 16'h0000, 16'h0000);
    run_line("c2");

    do_reset();
    one_beat(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_line("c6");

    // Output stall after the first beat of a four-beat line.
    do_reset();
    one_beat(16'h4033, 16'h4033, 16'h4033, 16'h4033);
    model_line();
    hold_low = 1'b1;
    send_line();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (m_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("c4_first_valid", 512'(m_tvalid), 512'd1);
    hold_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (rcv_d.size() >= 1) break;
    end
    hold_low = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 5) begin
        check("c4_hold_data", m_tdata, exp_d[1]);
        check("c4_hold_valid", 512'(m_tvalid), 512'd1);
        check("c4_in_stall", 512'(s_tready), 512'd0);
      end
    end
    hold_low = 1'b0;
    finish_line("c4");

    // Reset right after the first output beat of a three-beat line.
    do_reset();
    one_beat(16'hC0AA, 16'h0000, 16'h0000, 16'h0000);
    send_line();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (m_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("c5_first_valid", 512'(m_tvalid), 512'd1);
    do_reset();
    one_beat(16'h0A55, 16'h3611, 16'h0000, 16'h0000);
    run_line("c5_after_rst");

    bp_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      if (r % 8 == 0) do_reset();
      gen_line(($urandom_range(0, 1) == 1) ? LP : int'($urandom_range(0, 320)));
      run_line("rnd");
    end
    bp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
